// File: rtl/output_port_mc.sv
// Multi-channel network output port: per-channel FIFOs with credit-gated,
// round-robin packet injection and per-channel destination headers.
module output_port_mc #(
  parameter int unsigned PACKET_BITS           = 97,
  parameter int unsigned NUM_LEAF_BITS         = 6,
  parameter int unsigned NUM_PORT_BITS         = 4,
  parameter int unsigned NUM_ADDR_BITS         = 7,
  parameter int unsigned PAYLOAD_BITS          = 64,
  parameter int unsigned NUM_CH                = 4,
  parameter int unsigned FIFO_ADDR_BITS        = 5,
  parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
  localparam int unsigned CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CH*PAYLOAD_BITS-1:0]   din,
  input  logic [NUM_CH-1:0]                vld,
  output logic [NUM_CH-1:0]                ack,
  input  logic [CH_BITS-1:0]               cfg_ch,
  input  logic [NUM_LEAF_BITS-1:0]         cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]         cfg_dst_port,
  input  logic [NUM_ADDR_BITS-1:0]         cfg_fifo_addr,
  input  logic [NUM_ADDR_BITS-1:0]         cfg_freespace,
  input  logic                             update_dst_en,
  input  logic                             update_fifo_addr_en,
  input  logic                             update_freespace_en,
  input  logic [CH_BITS-1:0]               credit_ch,
  input  logic                             add_freespace_en,
  input  logic                             rd_en_sel,
  output logic [PACKET_BITS-1:0]           internal_out,
  output logic                             empty
);

  localparam int unsigned DEPTH      = 2 ** FIFO_ADDR_BITS;
  localparam int unsigned PTR_BITS   = FIFO_ADDR_BITS + 1;
  localparam int unsigned CREDIT_MAX = 2 ** NUM_ADDR_BITS - 1;
  localparam int unsigned RSV_BITS   = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS
                                       - NUM_ADDR_BITS - PAYLOAD_BITS;

  logic [PAYLOAD_BITS-1:0]  mem        [NUM_CH][DEPTH];
  logic [PTR_BITS-1:0]      wr_ptr     [NUM_CH];
  logic [PTR_BITS-1:0]      rd_ptr     [NUM_CH];
  logic [NUM_ADDR_BITS-1:0] credit     [NUM_CH];
  logic [NUM_ADDR_BITS-1:0] credit_nxt [NUM_CH];
  logic [31:0]              credit_sum [NUM_CH];
  logic [NUM_ADDR_BITS-1:0] addr       [NUM_CH];
  logic [NUM_LEAF_BITS-1:0] leaf       [NUM_CH];
  logic [NUM_PORT_BITS-1:0] port       [NUM_CH];

  logic [NUM_CH-1:0]        full;
  logic [NUM_CH-1:0]        eligible;
  logic [NUM_CH-1:0]        push;
  logic [NUM_CH-1:0]        pop_ch;
  logic [CH_BITS-1:0]       last_grant;
  logic [CH_BITS-1:0]       grant;
  logic [CH_BITS-1:0]       idx;
  logic                     found;
  logic                     pop;
  logic [PAYLOAD_BITS-1:0]  head_data_c;
  logic [PACKET_BITS-1:0]   pkt_c;

  // FIFO status and channel eligibility
  always_comb begin
    full     = '0;
    eligible = '0;
    push     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]     = (wr_ptr[c] == {~rd_ptr[c][FIFO_ADDR_BITS], rd_ptr[c][FIFO_ADDR_BITS-1:0]});
      eligible[c] = (wr_ptr[c] != rd_ptr[c]) && (credit[c] != '0);
      push[c]     = vld[c] && !full[c];
    end
  end

  assign ack   = ~full;
  assign empty = ~|eligible;

  // Round-robin search starting just after the last granted channel
  always_comb begin
    grant = last_grant;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = CH_BITS'((32'(last_grant) + 32'(i)) % NUM_CH);
      if (!found && eligible[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  assign pop = rd_en_sel && found;

  always_comb begin
    pop_ch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop_ch[c] = pop && (grant == CH_BITS'(c));
    end
  end

  assign head_data_c = mem[grant][rd_ptr[grant][FIFO_ADDR_BITS-1:0]];

  generate
    if (RSV_BITS > 0) begin : g_rsv
      assign pkt_c = {1'b1, leaf[grant], port[grant], {RSV_BITS{1'b0}}, addr[grant], head_data_c};
    end else begin : g_no_rsv
      assign pkt_c = {1'b1, leaf[grant], port[grant], addr[grant], head_data_c};
    end
  endgenerate

  // Credit update: load beats add, pop+add nets to SIZE-1, adds saturate
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      credit_sum[c] = 32'(credit[c]) + 32'(FREESPACE_UPDATE_SIZE) - 32'(pop_ch[c]);
      credit_nxt[c] = credit[c];
      if (update_freespace_en && (cfg_ch == CH_BITS'(c))) begin
        credit_nxt[c] = cfg_freespace;
      end else if (add_freespace_en && (credit_ch == CH_BITS'(c))) begin
        credit_nxt[c] = (credit_sum[c] > CREDIT_MAX) ? NUM_ADDR_BITS'(CREDIT_MAX)
                                                     : NUM_ADDR_BITS'(credit_sum[c]);
      end else if (pop_ch[c]) begin
        credit_nxt[c] = credit[c] - NUM_ADDR_BITS'(1);
      end
    end
  end

  // FIFO storage; pointers alone define contents, so no reset here
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c][FIFO_ADDR_BITS-1:0]] <= din[c*PAYLOAD_BITS +: PAYLOAD_BITS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant   <= CH_BITS'(NUM_CH - 1);
      internal_out <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        credit[c] <= NUM_ADDR_BITS'(CREDIT_MAX);
        addr[c]   <= '0;
        leaf[c]   <= '0;
        port[c]   <= '0;
      end
    end else begin
      internal_out <= pop ? pkt_c : '0;
      if (pop) begin
        last_grant <= grant;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        credit[c] <= credit_nxt[c];
        if (push[c]) begin
          wr_ptr[c] <= wr_ptr[c] + PTR_BITS'(1);
        end
        if (pop_ch[c]) begin
          rd_ptr[c] <= rd_ptr[c] + PTR_BITS'(1);
        end
        if (update_dst_en && (cfg_ch == CH_BITS'(c))) begin
          leaf[c] <= cfg_dst_leaf;
          port[c] <= cfg_dst_port;
        end
        if (update_fifo_addr_en && (cfg_ch == CH_BITS'(c))) begin
          addr[c] <= cfg_fifo_addr;
        end else if (pop_ch[c]) begin
          addr[c] <= addr[c] + NUM_ADDR_BITS'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_output_port_mc.sv
// Scoreboard bench for output_port_mc: expected packets are queued as words
// are pushed and compared as packets leave the port.
module tb_output_port_mc;

  logic         clk;
  logic         reset;
  logic [255:0] din;
  logic [3:0]   vld;
  logic [3:0]   ack;
  logic [1:0]   cfg_ch;
  logic [5:0]   cfg_dst_leaf;
  logic [3:0]   cfg_dst_port;
  logic [6:0]   cfg_fifo_addr;
  logic [6:0]   cfg_freespace;
  logic         update_dst_en;
  logic         update_fifo_addr_en;
  logic         update_freespace_en;
  logic [1:0]   credit_ch;
  logic         add_freespace_en;
  logic         rd_en_sel;
  logic [96:0]  internal_out;
  logic         empty;

  int           n_checks;
  int           n_fail;
  logic [96:0]  q[$];
  logic [6:0]   exp_addr;
  logic [63:0]  next_word;
  int           n_out;

  output_port_mc dut (
    .clk                 (clk),
    .reset               (reset),
    .din                 (din),
    .vld                 (vld),
    .ack                 (ack),
    .cfg_ch              (cfg_ch),
    .cfg_dst_leaf        (cfg_dst_leaf),
    .cfg_dst_port        (cfg_dst_port),
    .cfg_fifo_addr       (cfg_fifo_addr),
    .cfg_freespace       (cfg_freespace),
    .update_dst_en       (update_dst_en),
    .update_fifo_addr_en (update_fifo_addr_en),
    .update_freespace_en (update_freespace_en),
    .credit_ch           (credit_ch),
    .add_freespace_en    (add_freespace_en),
    .rd_en_sel           (rd_en_sel),
    .internal_out        (internal_out),
    .empty               (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [96:0] mk_pkt(input logic [5:0] lf, input logic [3:0] pt,
                                         input logic [6:0] ad, input logic [63:0] d);
    return {1'b1, lf, pt, 15'd0, ad, d};
  endfunction

  function automatic logic [96:0] pop_exp();
    if (q.size() == 0) return '0;
    return q.pop_front();
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    vld = '0; din = '0; rd_en_sel = 1'b0;
    update_dst_en = 1'b0; update_fifo_addr_en = 1'b0; update_freespace_en = 1'b0;
    add_freespace_en = 1'b0; cfg_ch = '0; credit_ch = '0;
    tick();
    tick();
    reset = 1'b0;
    q.delete();
    exp_addr  = '0;
    next_word = 64'h5000;
    tick();
    check("rst_out", 128'(internal_out), 128'(0));
    check("rst_empty", 128'(empty), 128'(1));
    check("rst_ack", 128'(ack), 128'(4'hF));
  endtask

  task automatic cfg_dst(input int ch, input logic [5:0] lf, input logic [3:0] pt);
    cfg_ch = 2'(ch); cfg_dst_leaf = lf; cfg_dst_port = pt; update_dst_en = 1'b1;
    tick();
    update_dst_en = 1'b0;
  endtask

  task automatic cfg_addr(input int ch, input logic [6:0] a);
    cfg_ch = 2'(ch); cfg_fifo_addr = a; update_fifo_addr_en = 1'b1;
    tick();
    update_fifo_addr_en = 1'b0;
  endtask

  task automatic cfg_free(input int ch, input logic [6:0] f);
    cfg_ch = 2'(ch); cfg_freespace = f; update_freespace_en = 1'b1;
    tick();
    update_freespace_en = 1'b0;
  endtask

  task automatic push_word(input int ch, input logic [63:0] d);
    vld[ch] = 1'b1;
    din[ch*64 +: 64] = d;
    tick();
    vld[ch] = 1'b0;
  endtask

  // Each of the next n cycles must carry the next queued packet
  task automatic expect_stream(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, 128'(internal_out), 128'(pop_exp()));
    end
  endtask

  // Stream channel 0 with leaf/port 0 and count packets that leave
  task automatic stream_ch0(input int cycles, input bit add_first, output int cnt);
    cnt = 0;
    rd_en_sel = 1'b1;
    credit_ch = 2'd0;
    for (int i = 0; i < cycles; i++) begin
      vld[0] = 1'b1;
      din[63:0] = next_word;
      add_freespace_en = add_first && (i == 0);
      if (ack[0]) begin
        q.push_back(mk_pkt(6'd0, 4'd0, exp_addr, next_word));
        exp_addr++;
        next_word++;
      end
      tick();
      if (internal_out[96]) begin
        cnt++;
        check("stream_pkt", 128'(internal_out), 128'(pop_exp()));
      end
    end
    vld[0] = 1'b0;
    rd_en_sel = 1'b0;
    add_freespace_en = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cfg_dst_leaf = '0; cfg_dst_port = '0; cfg_fifo_addr = '0; cfg_freespace = '0;

    // Single channel with configured header and starting address
    do_reset();
    cfg_ch = 2'd0; cfg_dst_leaf = 6'd5; cfg_dst_port = 4'd2; cfg_fifo_addr = 7'd10;
    update_dst_en = 1'b1; update_fifo_addr_en = 1'b1;
    tick();
    update_dst_en = 1'b0; update_fifo_addr_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push_word(0, 64'hA000 + 64'(k));
      q.push_back(mk_pkt(6'd5, 4'd2, 7'(10 + k), 64'hA000 + 64'(k)));
    end
    check("single_idle_out", 128'(internal_out), 128'(0));
    rd_en_sel = 1'b1;
    expect_stream(3, "single_pkt");
    tick();
    check("single_after_out", 128'(internal_out), 128'(0));
    check("single_after_empty", 128'(empty), 128'(1));
    rd_en_sel = 1'b0;

    // Round-robin across all channels, back to back
    do_reset();
    for (int c = 0; c < 4; c++) cfg_dst(c, 6'(c + 1), 4'(c + 8));
    for (int r = 0; r < 2; r++) begin
      vld = 4'hF;
      for (int c = 0; c < 4; c++) din[c*64 +: 64] = 64'h1000 * 64'(c) + 64'(r);
      tick();
      vld = '0;
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        q.push_back(mk_pkt(6'(c + 1), 4'(c + 8), 7'(r), 64'h1000 * 64'(c) + 64'(r)));
    rd_en_sel = 1'b1;
    expect_stream(8, "rr_pkt");
    tick();
    check("rr_after_out", 128'(internal_out), 128'(0));
    check("rr_after_empty", 128'(empty), 128'(1));
    rd_en_sel = 1'b0;

    // Credit stall and resume on channel 1
    do_reset();
    cfg_dst(1, 6'd7, 4'd3);
    cfg_free(1, 7'd2);
    for (int k = 0; k < 5; k++) push_word(1, 64'h100 + 64'(k));
    for (int k = 0; k < 2; k++) q.push_back(mk_pkt(6'd7, 4'd3, 7'(k), 64'h100 + 64'(k)));
    rd_en_sel = 1'b1;
    expect_stream(2, "stall_pkt");
    tick();
    check("stall_out", 128'(internal_out), 128'(0));
    check("stall_empty", 128'(empty), 128'(1));
    credit_ch = 2'd1; add_freespace_en = 1'b1;
    tick();
    add_freespace_en = 1'b0;
    for (int k = 2; k < 5; k++) q.push_back(mk_pkt(6'd7, 4'd3, 7'(k), 64'h100 + 64'(k)));
    expect_stream(3, "resume_pkt");
    tick();
    check("resume_after_out", 128'(internal_out), 128'(0));
    rd_en_sel = 1'b0;

    // Pop and add in the same cycle from credit 3 allows 67 packets in total
    do_reset();
    cfg_free(0, 7'd3);
    q.push_back(mk_pkt(6'd0, 4'd0, exp_addr, next_word));
    push_word(0, next_word);
    exp_addr++;
    next_word++;
    stream_ch0(80, 1'b1, n_out);
    check("popadd_count", 128'(n_out), 128'(67));
    check("popadd_empty", 128'(empty), 128'(1));
    // Load 120 then add 64 saturates at 127
    cfg_free(0, 7'd120);
    credit_ch = 2'd0; add_freespace_en = 1'b1;
    tick();
    add_freespace_en = 1'b0;
    stream_ch0(150, 1'b0, n_out);
    check("sat_count", 128'(n_out), 128'(127));

    // Full FIFO on channel 2
    do_reset();
    for (int k = 0; k < 32; k++) begin
      push_word(2, 64'h2000 + 64'(k));
      q.push_back(mk_pkt(6'd0, 4'd0, 7'(k), 64'h2000 + 64'(k)));
    end
    check("full_ack", 128'(ack), 128'(4'hB));
    vld[2] = 1'b1; din[128 +: 64] = 64'hDEAD;
    tick();
    tick();
    vld[2] = 1'b0;
    check("full_ack_hold", 128'(ack), 128'(4'hB));
    rd_en_sel = 1'b1;
    expect_stream(32, "full_drain");
    tick();
    check("full_after_out", 128'(internal_out), 128'(0));
    check("full_after_empty", 128'(empty), 128'(1));
    rd_en_sel = 1'b0;

    // Reset while streaming suppresses the pending packet and restores state
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push_word(3, 64'h3000 + 64'(k));
      q.push_back(mk_pkt(6'd0, 4'd0, 7'(k), 64'h3000 + 64'(k)));
    end
    rd_en_sel = 1'b1;
    expect_stream(1, "midrst_first");
    reset = 1'b1;
    tick();
    check("midrst_out", 128'(internal_out), 128'(0));
    check("midrst_empty", 128'(empty), 128'(1));
    check("midrst_ack", 128'(ack), 128'(4'hF));
    reset = 1'b0;
    rd_en_sel = 1'b0;
    q.delete();
    exp_addr  = '0;
    next_word = 64'h7000;
    tick();
    check("postrst_out", 128'(internal_out), 128'(0));
    stream_ch0(140, 1'b0, n_out);
    check("postrst_credit_count", 128'(n_out), 128'(127));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/output_port_mc.md
OUTPUT_PORT_MC -- requirements
Module: output_port_mc

Interface
REQ-001 SHALL have parameter PACKET_BITS, default 97, network packet width.
REQ-002 SHALL have parameters NUM_LEAF_BITS 6, NUM_PORT_BITS 4, NUM_ADDR_BITS 7, PAYLOAD_BITS 64: header field and payload widths.
REQ-003 SHALL have parameter NUM_CH, default 4, number of user output channels (1..16).
REQ-004 SHALL have parameter FIFO_ADDR_BITS, default 5; per-channel FIFO depth is 2**FIFO_ADDR_BITS.
REQ-005 SHALL have parameter FREESPACE_UPDATE_SIZE, default 64, credits returned per credit pulse.
REQ-006 SHALL have ports: clk in 1, clock; reset in 1, reset, synchronous, active-high.
REQ-007 SHALL have ports: din in NUM_CH*PAYLOAD_BITS, user data (channel c at bits c*PAYLOAD_BITS+:PAYLOAD_BITS); vld in NUM_CH, user valid; ack out NUM_CH, user accept.
REQ-008 SHALL have config ports: cfg_ch in clog2(NUM_CH), target channel; cfg_dst_leaf in NUM_LEAF_BITS; cfg_dst_port in NUM_PORT_BITS; cfg_fifo_addr in NUM_ADDR_BITS; cfg_freespace in NUM_ADDR_BITS; update_dst_en, update_fifo_addr_en, update_freespace_en in 1 each.
REQ-009 SHALL have credit ports: credit_ch in clog2(NUM_CH); add_freespace_en in 1.
REQ-010 SHALL have network ports: rd_en_sel in 1, network ready; internal_out out PACKET_BITS; empty out 1, no channel eligible.

Function
REQ-011 Each channel SHALL own a FIFO; ack[c] = ~full[c]; push when vld[c] && ack[c]; push to full FIFO never occurs.
REQ-012 Channel c SHALL be eligible when its FIFO is non-empty and its credit counter > 0; empty = no channel eligible.
REQ-013 When rd_en_sel && !empty, exactly one eligible channel SHALL be popped, chosen round-robin starting at (last_grant+1) mod NUM_CH; last_grant resets to NUM_CH-1.
REQ-014 The popped word SHALL appear on internal_out exactly one cycle after the pop, as {1'b1, leaf[c], port[c], zero reserved bits, addr[c], data}; reserved field omitted when its width is 0.
REQ-015 internal_out SHALL be all zeros in any cycle not following a pop.
REQ-016 addr[c] SHALL increment by 1 (mod 2**NUM_ADDR_BITS) on the cycle the channel-c packet is output; update_fifo_addr_en for c overrides the increment.
REQ-017 Credit counter c (NUM_ADDR_BITS wide) SHALL update with priority: update_freespace_en -> load cfg_freespace; else pop and add -> +FREESPACE_UPDATE_SIZE-1; else add only -> +FREESPACE_UPDATE_SIZE; else pop only -> -1; else hold.
REQ-018 Credit addition SHALL saturate at 2**NUM_ADDR_BITS-1; decrement never goes below 0 (guaranteed by REQ-012).
REQ-019 update_dst_en SHALL load leaf[cfg_ch], port[cfg_ch]; new values apply to pops occurring the following cycle onward.
REQ-020 Config and credit operations on a channel other than the one popped SHALL apply independently in the same cycle.
REQ-021 Sustained throughput SHALL be one packet per cycle while rd_en_sel is high and any channel is eligible.
REQ-022 Data order within a channel SHALL be preserved; no word is duplicated or dropped.

Reset
REQ-023 On reset all FIFOs SHALL flush; internal_out = 0, empty = 1, ack = all ones the cycle after reset deasserts.
REQ-024 Reset values: credits 2**NUM_ADDR_BITS-1, addr 0, leaf 0, port 0, last_grant NUM_CH-1.
REQ-025 Reset asserted mid-stream SHALL suppress any packet pending output in the following cycle.

Verification
REQ-026 Single channel: cfg ch0 leaf=5 port=2 addr=10; push 3 words, rd_en_sel=1 -> three packets with addr 10,11,12, header leaf 5 port 2, one cycle after each pop.
REQ-027 Round-robin: all 4 channels loaded with 2 words, rd_en_sel=1 -> grant order 0,1,2,3,0,1,2,3, 8 consecutive valid cycles.
REQ-028 Credit stall: ch1 freespace=2, 5 words queued -> exactly 2 packets, empty=1; add_freespace_en ch1 -> remaining 3 sent.
REQ-029 Simultaneous pop and add on ch0 with credit 3 -> credit becomes 3+64-1=66; add at 120 -> saturates at 127.
REQ-030 Full FIFO: push 32 words into ch2 with rd_en_sel=0 -> ack[2]=0 after 32nd; extra vld ignored; drain yields exactly 32 in order.
REQ-031 Reset during streaming -> internal_out 0 next cycle, empty=1, credits 127, addr 0.
